// File: rtl/synth_cfg_scheduler.sv
// Shares the byte-wide cfg write port between the host byte interface and a
// periodic clamped sweep engine that steps one configuration byte.
module synth_cfg_scheduler #(
    parameter int CFG_ADDR_BITS  = 3,
    parameter int SWEEP_DIV_BITS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic [CFG_ADDR_BITS:0]    host_addr,
    input  logic [7:0]                host_data,
    input  logic                      sweep_en,
    input  logic [CFG_ADDR_BITS:0]    sweep_addr,
    input  logic [7:0]                sweep_step,
    input  logic [SWEEP_DIV_BITS-1:0] sweep_period,
    input  logic [7:0]                sweep_lo,
    input  logic [7:0]                sweep_hi,
    output logic [1:0]                cfg_we,
    output logic [CFG_ADDR_BITS-1:0]  cfg_w_addr,
    output logic [15:0]               cfg_w_data,
    output logic [7:0]                sweep_value
);

    // state       | meaning
    // GRANT_SWEEP | sweep won the most recent grant; host wins the next conflict
    // GRANT_HOST  | host won the most recent grant; sweep wins the next conflict
    typedef enum logic {
        GRANT_SWEEP = 1'b0,
        GRANT_HOST  = 1'b1
    } grant_t;

    grant_t                    last_grant;
    grant_t                    last_grant_next;
    logic [SWEEP_DIV_BITS-1:0] sweep_cnt;
    logic                      sweep_pending;
    logic                      sweep_tick;
    logic                      grant_host;
    logic                      grant_sweep;
    logic [7:0]                shadow;
    logic [7:0]                sweep_new;
    logic signed [9:0]         sweep_sum;

    assign sweep_tick  = sweep_en && (sweep_cnt == '0);
    assign sweep_value = shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_SWEEP;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant;
        if (grant_host) begin
            last_grant_next = GRANT_HOST;
        end else if (grant_sweep) begin
            last_grant_next = GRANT_SWEEP;
        end
    end

    // host_ready depends on registers only, so the host never sees a comb path
    // from its own valid.
    always_comb begin
        host_ready  = !(sweep_pending && (last_grant == GRANT_HOST));
        grant_host  = host_valid && host_ready;
        grant_sweep = sweep_pending && sweep_en && !grant_host;
    end

    always_comb begin
        sweep_sum = $signed({2'b00, shadow}) + $signed({{2{sweep_step[7]}}, sweep_step});
        if (sweep_lo > sweep_hi) begin
            sweep_new = sweep_lo;
        end else if (sweep_sum > $signed({2'b00, sweep_hi})) begin
            sweep_new = sweep_hi;
        end else if (sweep_sum < $signed({2'b00, sweep_lo})) begin
            sweep_new = sweep_lo;
        end else begin
            sweep_new = sweep_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt     <= '0;
            sweep_pending <= 1'b0;
        end else if (!sweep_en) begin
            sweep_cnt     <= sweep_period;
            sweep_pending <= 1'b0;
        end else begin
            sweep_cnt <= sweep_tick ? sweep_period : sweep_cnt - 1'b1;
            // a fresh tick outranks the grant so the new tick is not lost
            if (sweep_tick) begin
                sweep_pending <= 1'b1;
            end else if (grant_sweep) begin
                sweep_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_we     <= 2'b00;
            cfg_w_addr <= '0;
            cfg_w_data <= 16'h0000;
            shadow     <= 8'h00;
        end else begin
            cfg_we <= 2'b00;
            if (grant_host) begin
                cfg_we     <= host_addr[0] ? 2'b10 : 2'b01;
                cfg_w_addr <= host_addr[CFG_ADDR_BITS:1];
                cfg_w_data <= {host_data, host_data};
                if (host_addr == sweep_addr) begin
                    shadow <= host_data;
                end
            end else if (grant_sweep) begin
                cfg_we     <= sweep_addr[0] ? 2'b10 : 2'b01;
                cfg_w_addr <= sweep_addr[CFG_ADDR_BITS:1];
                cfg_w_data <= {sweep_new, sweep_new};
                shadow     <= sweep_new;
            end
        end
    end

endmodule

// File: tb/tb_synth_cfg_scheduler.sv
// Scoreboard bench for synth_cfg_scheduler: a behavioural model queues the
// expected cfg writes and a negedge monitor checks what the DUT emits.
module tb_synth_cfg_scheduler;

    logic        clk;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_addr;
    logic [7:0]  host_data;
    logic        sweep_en;
    logic [3:0]  sweep_addr;
    logic [7:0]  sweep_step;
    logic [11:0] sweep_period;
    logic [7:0]  sweep_lo;
    logic [7:0]  sweep_hi;
    logic [1:0]  cfg_we;
    logic [2:0]  cfg_w_addr;
    logic [15:0] cfg_w_data;
    logic [7:0]  sweep_value;

    synth_cfg_scheduler #(.CFG_ADDR_BITS(3), .SWEEP_DIV_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .sweep_en(sweep_en), .sweep_addr(sweep_addr), .sweep_step(sweep_step),
        .sweep_period(sweep_period), .sweep_lo(sweep_lo), .sweep_hi(sweep_hi),
        .cfg_we(cfg_we), .cfg_w_addr(cfg_w_addr), .cfg_w_data(cfg_w_data),
        .sweep_value(sweep_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  we;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    // reference model state
    int  m_cnt;
    bit  m_pend;
    bit  m_last_host;
    int  m_shadow;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0;
        m_pend = 0;
        m_last_host = 0;
        m_shadow = 0;
        exp_q.delete();
    endfunction

    function automatic wr_t make_wr(input logic [3:0] a, input int d);
        wr_t w;
        w.we   = a[0] ? 2'b10 : 2'b01;
        w.addr = a[3:1];
        w.data = {d[7:0], d[7:0]};
        return w;
    endfunction

    // one clock of stimulus: drive inputs, evaluate the model, advance the edge
    task automatic cyc(input logic hv, input logic [3:0] ha, input logic [7:0] hd);
        bit hr, gh, gs;
        int s, lo, hi, nv;
        host_valid = hv;
        host_addr  = ha;
        host_data  = hd;
        #1;
        hr = !(m_pend && m_last_host);
        gh = hv && hr;
        gs = m_pend && sweep_en && !gh;
        chk("host_ready", int'(host_ready), int'(hr));
        if (gh) begin
            exp_q.push_back(make_wr(ha, int'(hd)));
            if (ha == sweep_addr) m_shadow = int'(hd);
            m_last_host = 1;
        end else if (gs) begin
            s  = m_shadow + int'($signed(sweep_step));
            lo = int'(sweep_lo);
            hi = int'(sweep_hi);
            if (lo > hi)      nv = lo;
            else if (s > hi)  nv = hi;
            else if (s < lo)  nv = lo;
            else              nv = s;
            exp_q.push_back(make_wr(sweep_addr, nv));
            m_shadow = nv;
            m_last_host = 0;
        end
        if (!sweep_en) begin
            m_cnt  = int'(sweep_period);
            m_pend = 0;
        end else if (m_cnt == 0) begin
            m_cnt  = int'(sweep_period);
            m_pend = 1;
        end else begin
            m_cnt = m_cnt - 1;
            if (gs) m_pend = 0;
        end
        @(posedge clk);
        #1;
        chk("sweep_value", int'(sweep_value), m_shadow);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 8'h00);
    endtask

    // waits until the model has a sweep pending; expiry counts as a failure
    task automatic wait_pending();
        int k = 0;
        while (!m_pend && k < 200) begin
            cyc(1'b0, 4'h0, 8'h00);
            k++;
        end
        chk("pending_timeout", int'(m_pend), 1);
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (rst_n && cfg_we != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: we=%b addr=%0d data=0x%04h at %0t",
                         cfg_we, cfg_w_addr, cfg_w_data, $time);
            end else begin
                w = exp_q.pop_front();
                if (cfg_we != w.we || cfg_w_addr != w.addr || cfg_w_data != w.data) begin
                    fails++;
                    $display("FAIL cfg_write: got we=%b addr=%0d data=0x%04h expected we=%b addr=%0d data=0x%04h at %0t",
                             cfg_we, cfg_w_addr, cfg_w_data, w.we, w.addr, w.data, $time);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        host_valid = 1'b0; host_addr = 4'h0; host_data = 8'h00;
        sweep_en = 1'b0; sweep_addr = 4'b0110; sweep_step = 8'd5;
        sweep_period = 12'd9; sweep_lo = 8'h00; sweep_hi = 8'hFF;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_cfg_we", int'(cfg_we), 0);
        chk("rst_cfg_w_addr", int'(cfg_w_addr), 0);
        chk("rst_cfg_w_data", int'(cfg_w_data), 0);
        chk("rst_sweep_value", int'(sweep_value), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // idle, then the basic host byte write
        idle(6);
        cyc(1'b1, 4'b0101, 8'h3C);
        chk("host_we", int'(cfg_we), 2);
        chk("host_addr", int'(cfg_w_addr), 2);
        chk("host_data", int'(cfg_w_data), 16'h3C3C);
        idle(2);

        // periodic sweep +5 every 10 cycles
        sweep_en = 1'b1;
        idle(32);
        chk("sweep_3_steps", int'(sweep_value), 15);

        // saturation at hi, then large negative step saturating at lo
        sweep_en = 1'b0;
        idle(1);
        cyc(1'b1, 4'b0110, 8'hFC);
        sweep_hi = 8'hFE;
        sweep_en = 1'b1;
        idle(22);
        chk("sat_hi", int'(sweep_value), 8'hFE);
        sweep_step = 8'h80;
        sweep_lo = 8'h10;
        wait_pending();
        idle(1);
        chk("neg_step", int'(sweep_value), 8'h7E);
        wait_pending();
        idle(1);
        chk("sat_lo", int'(sweep_value), 8'h10);

        // continuous host traffic with a tick every cycle
        sweep_en = 1'b0;
        sweep_step = 8'd1; sweep_lo = 8'h00; sweep_hi = 8'hFF;
        sweep_period = 12'd0;
        idle(1);
        sweep_en = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1'b1, 4'b0001 + 4'(2 * (i % 3)), 8'(i + 1));

        // host write to the target while a sweep is pending
        sweep_en = 1'b0;
        sweep_period = 12'd5;
        idle(1);
        cyc(1'b1, 4'b0110, 8'h20);
        sweep_en = 1'b1;
        wait_pending();
        idle(1);
        wait_pending();
        cyc(1'b1, 4'b0110, 8'h80);
        idle(1);
        chk("host_then_sweep", int'(sweep_value), 8'h81);

        // dropping sweep_en with a tick pending must not produce a write
        wait_pending();
        sweep_en = 1'b0;
        idle(8);

        // asynchronous reset with a write on the port
        sweep_en = 1'b1;
        sweep_period = 12'd0;
        cyc(1'b1, 4'b1011, 8'h5A);
        rst_n = 1'b0;
        #1;
        chk("arst_cfg_we", int'(cfg_we), 0);
        chk("arst_cfg_w_data", int'(cfg_w_data), 0);
        chk("arst_sweep_value", int'(sweep_value), 0);
        chk("arst_host_ready", int'(host_ready), 1);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        cyc(1'b1, 4'b0011, 8'hA5);
        idle(3);

        // randomized traffic and configuration
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ha;
            if (i % 40 == 0) begin
                sweep_en     = ($urandom_range(0, 9) < 8);
                sweep_addr   = 4'($urandom_range(0, 15));
                sweep_step   = 8'($urandom);
                sweep_period = 12'($urandom_range(0, 7));
                sweep_lo     = 8'($urandom);
                sweep_hi     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(int'(sweep_lo), 255));
            end
            ha = ($urandom_range(0, 3) == 0) ? sweep_addr : 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), ha, 8'($urandom));
        end

        sweep_en = 1'b0;
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/synth_cfg_scheduler.md
# synth_cfg_scheduler

Write-port scheduler for the synth's 8×16-bit configuration register file. It shares the single byte-wide cfg write port between two requesters: the external host byte interface and an internal sweep engine. The sweep engine periodically steps one configuration byte by a signed amount, clamped to a range, to produce filter, volume or pitch sweeps without host traffic. It sits between the `ui_in`/`uio_in` strobe decoder and the cfg register file, and drives its `cfg_we`/`cfg_w_addr`/`cfg_w_data` inputs.

## Interface
- `CFG_ADDR_BITS`, 3: cfg word address width (8 words).
- `SWEEP_DIV_BITS`, 12: width of sweep period counter.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `host_valid` in 1: host byte write request.
- `host_ready` out 1: host write accepted this cycle when high together with `host_valid`.
- `host_addr` in CFG_ADDR_BITS+1: {word address, byte select}; bit 0 = 1 selects the high byte.
- `host_data` in 8: host byte.
- `sweep_en` in 1: enables the sweep engine.
- `sweep_addr` in CFG_ADDR_BITS+1: target byte, same encoding as `host_addr`.
- `sweep_step` in 8: signed two's-complement step per sweep tick.
- `sweep_period` in SWEEP_DIV_BITS: tick interval minus 1, in clk cycles.
- `sweep_lo`, `sweep_hi` in 8: unsigned clamp bounds (inclusive).
- `cfg_we` out 2: byte enables to the cfg file; at most one bit is set.
- `cfg_w_addr` out CFG_ADDR_BITS: word address.
- `cfg_w_data` out 16: {byte, byte}; the byte is duplicated on both halves.
- `sweep_value` out 8: current shadow value of the swept byte.

## Operation
- **Reset values:**
  - `cfg_we`=0, `cfg_w_addr`=0, `cfg_w_data`=0.
  - `sweep_value` (shadow)=0, which matches the cfg file reset.
  - Sweep counter=0, `sweep_pending`=0, `last_grant`=SWEEP.
  - `host_ready`=1.
- **Sweep timer:**
  - While `sweep_en`=1, the counter decrements each cycle.
  - At 0 it reloads `sweep_period` and raises a tick, so ticks occur every `sweep_period`+1 cycles.
  - A tick sets `sweep_pending`. A tick arriving while `sweep_pending` is already set is dropped; ticks do not accumulate.
  - While `sweep_en`=0, the counter is held at `sweep_period` and `sweep_pending` is cleared at once.
- **Arbitration (one write per cycle):**
  - Only host requesting: host granted.
  - Only sweep pending: sweep granted.
  - Both: the requester that did not win the last conflict is granted. Grants without a conflict also update `last_grant`.
  - `host_ready` = !(`sweep_pending` && `last_grant`==HOST). It is combinational from registers and has no dependency on `host_valid`.
- **Host grant:**
  - Registers `cfg_we` = one-hot of `host_addr[0]`, `cfg_w_addr` = `host_addr[CFG_ADDR_BITS:1]`, `cfg_w_data` = {`host_data`, `host_data`}.
  - If `host_addr`==`sweep_addr`, the shadow is also loaded with `host_data`. This is independent of `sweep_en`.
- **Sweep grant:**
  - sum = shadow (zero-extended) + `sweep_step` (sign-extended), computed in 10-bit signed.
  - new = sum>hi ? hi : (sum<lo ? lo : sum). If lo>hi the result is lo.
  - Shadow <= new. A write to `sweep_addr` is issued with data new. `sweep_pending` is cleared.
  - `sweep_addr`, step and bounds are sampled at grant time, not at tick time.
- A tick in the same cycle as a sweep grant sets pending again, so the grant consumes only the older tick.

## Timing
- The write port is registered. A request accepted or granted in cycle N appears on `cfg_*` in cycle N+1 for exactly one cycle. `cfg_we` returns to 0 afterwards unless there is another grant.
- `sweep_value` updates in the same edge as the corresponding cfg write.
- Worst-case host wait is 1 cycle when a sweep is pending. Worst-case sweep wait is 1 cycle under continuous host traffic.
- `rst_n` asserted mid-operation clears all state asynchronously; any write in flight is lost. The first grant after release has no latency penalty.
- `sweep_period`=0 gives a tick every cycle. Under continuous host traffic this yields alternating host/sweep writes.

## Test plan
- Reset, then idle with `sweep_en`=0 → `cfg_we`=0 forever and `host_ready`=1. A host write of addr=0b0101, data=0x3C → next cycle `cfg_we`=2'b10, `cfg_w_addr`=2, `cfg_w_data`=0x3C3C.
- `sweep_en`=1, period=9, step=+5, lo=0, hi=0xFF, target 0b0110 → a write every 10 cycles with data 5, 10, 15…; `cfg_we`=2'b01, `cfg_w_addr`=3.
- Saturation: host sets the target to 0xFC, step=+5, hi=0xFE → next sweep writes 0xFE, then 0xFE again. With step=−128, lo=0x10 → 0x7E, then 0x10.
- Conflict: `host_valid` held high continuously with period=0 → strict alternation, host first (reset `last_grant`=SWEEP). `host_ready` toggles 1,0,1,0.
- Host write to the sweep target while a sweep is pending: shadow=0x20, host writes 0x80 and is granted first, step=+1 → the sweep then writes 0x81.
- `sweep_en` dropped with `sweep_pending` set → no sweep write follows. Assert `rst_n` mid-stream → all outputs go to reset values within the same cycle.
